// File: rtl/stream_filter_pkg.sv
// Shared definitions for the stream filter datapath.
//   state_t  : window generator control states
//   WIN_TAPS : number of pixels in one 3x3 window
//   win_idx  : flat slice index of window pixel (row i, column j), 0 = top-left
package stream_filter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int WIN_TAPS = 9;

  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/window_3x3_if.sv
// Pixel stream in / window stream out bundle for window_3x3.
//   up_data   : input pixel
//   up_val    : input pixel qualifier (no backpressure)
//   dn_window : 3x3 window, slice k = 3*i+j, k=0 top-left, k=8 newest pixel
//   dn_val    : one-cycle window qualifier
//   dn_last   : final window of the frame (only together with dn_val)
// master drives the pixel stream and observes windows; slave is the generator.
interface window_3x3_if
  import stream_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 8
);
  logic [IMG_WIDTH-1:0]          up_data;
  logic                          up_val;
  logic [WIN_TAPS*IMG_WIDTH-1:0] dn_window;
  logic                          dn_val;
  logic                          dn_last;

  modport master (
    output up_data, up_val,
    input  dn_window, dn_val, dn_last
  );

  modport slave (
    input  up_data, up_val,
    output dn_window, dn_val, dn_last
  );
endinterface

// File: rtl/delay_mem.sv
// Programmable row-delay memory (circular buffer).
//   clk, rst_n : clock, asynchronous active-low reset (control only)
//   clr        : restarts the buffer pointer at 0; contents are kept
//   delay      : delay in accepted beats, 1..2^AWIDTH
//   up_data    : sample written on each up_val
//   up_val     : write/advance strobe
//   dn_data    : sample written exactly 'delay' accepted beats earlier,
//                registered, updates only on up_val
//   dn_val     : up_val delayed by one clock
module delay_mem #(
  parameter int DATA_W = 8,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [AWIDTH-1:0] delay,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_val,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_val
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] ptr;
  logic [AWIDTH-1:0] ptr_last;

  // The pointer cycles over 'delay' entries, so the slot read before the
  // write always holds the sample from exactly 'delay' beats ago.
  assign ptr_last = delay - AWIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      dn_val <= 1'b0;
    end else begin
      dn_val <= up_val;
      if (clr) begin
        ptr <= '0;
      end else if (up_val) begin
        ptr <= (ptr == ptr_last) ? '0 : ptr + AWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up_val) begin
      mem[ptr] <= up_data;
      dn_data  <= mem[ptr];
    end
  end
endmodule

// File: rtl/window_3x3.sv
// Sliding 3x3 window generator over a raster pixel stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_width, cfg_height : frame size W x H, latched on cfg_set
//   cfg_set               : restart strobe, aborts any frame in progress
//   cfg_err               : latched configuration is illegal
//   strm                  : pixel in / window out (window_3x3_if.slave)
// Emits one window per pixel (r,c) with r>=2 and c>=2, two cycles after the
// pixel beat; dn_last flags pixel (H-1, W-1).
module window_3x3
  import stream_filter_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MEM_AWIDTH-1:0] cfg_width,
  input  logic [MEM_AWIDTH-1:0] cfg_height,
  input  logic                  cfg_set,
  output logic                  cfg_err,
  window_3x3_if.slave           strm
);
  localparam logic [MEM_AWIDTH-1:0] ONE     = MEM_AWIDTH'(1);
  localparam logic [MEM_AWIDTH-1:0] EDGE    = MEM_AWIDTH'(2);
  localparam logic [MEM_AWIDTH-1:0] DIM_MIN = MEM_AWIDTH'(3);
  // Widest legal row leaves one spare memory slot (MEM_DEPTH-1 is illegal).
  localparam logic [MEM_AWIDTH-1:0] W_LIMIT = '1;

  state_t                state, state_nxt;
  logic                  cfg_cnt;
  logic                  cfg_done;
  logic                  mem_clr;
  logic [MEM_AWIDTH-1:0] lat_w, w_m1, h_m1;
  logic                  cfg_bad;
  logic [MEM_AWIDTH-1:0] col, row;
  logic                  acc, win_ok, win_end;

  logic [IMG_WIDTH-1:0]  tap1_data, tap2_data;
  logic                  tap1_vld, tap2_vld;
  logic [IMG_WIDTH-1:0]  pix_p1;
  logic                  vld_p1, win_p1, last_p1;

  logic [IMG_WIDTH-1:0]  new_col [3];
  logic [IMG_WIDTH-1:0]  hist    [3][2];
  logic [WIN_TAPS-1:0][IMG_WIDTH-1:0] win_nxt;

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cfg_cnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_cnt <= (state == S_CFG && !cfg_set) ? ~cfg_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_done  = 1'b0;
    mem_clr   = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_IDLE;
      S_CFG: begin
        mem_clr = 1'b1;
        if (cfg_cnt) begin
          cfg_done  = 1'b1;
          state_nxt = cfg_bad ? S_IDLE : S_RUN;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (cfg_set) begin
      state_nxt = S_CFG;
      cfg_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_w   <= '0;
      w_m1    <= '0;
      h_m1    <= '0;
      cfg_bad <= 1'b0;
    end else if (cfg_set) begin
      lat_w   <= cfg_width;
      w_m1    <= cfg_width - ONE;
      h_m1    <= cfg_height - ONE;
      cfg_bad <= (cfg_width < DIM_MIN) || (cfg_width == W_LIMIT) ||
                 (cfg_height < DIM_MIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (cfg_done) begin
      cfg_err <= cfg_bad;
    end
  end

  // A pixel coinciding with cfg_set is dropped.
  assign acc     = strm.up_val && (state == S_RUN) && !cfg_set;
  assign win_ok  = acc && (row >= EDGE) && (col >= EDGE);
  assign win_end = win_ok && (row == h_m1) && (col == w_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (cfg_set) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col == w_m1) begin
        col <= '0;
        row <= (row == h_m1) ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

  // Stage 1: row memory read and input pixel register.
  // tap2 samples tap1's registered output, which still holds the value read
  // on the previous accepted beat, so a delay of W-1 lands exactly 2W back.
  delay_mem #(
    .DATA_W (IMG_WIDTH),
    .AWIDTH (MEM_AWIDTH)
  ) u_tap1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mem_clr),
    .delay   (lat_w),
    .up_data (strm.up_data),
    .up_val  (acc),
    .dn_data (tap1_data),
    .dn_val  (tap1_vld)
  );

  delay_mem #(
    .DATA_W (IMG_WIDTH),
    .AWIDTH (MEM_AWIDTH)
  ) u_tap2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mem_clr),
    .delay   (w_m1),
    .up_data (tap1_data),
    .up_val  (acc),
    .dn_data (tap2_data),
    .dn_val  (tap2_vld)
  );

  always_ff @(posedge clk) begin
    if (acc) begin
      pix_p1 <= strm.up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      win_p1  <= win_ok;
      last_p1 <= win_end;
    end
  end

  // Both memories see the same strobe; their valids mark the pipeline beat.
  assign vld_p1 = tap1_vld & tap2_vld;

  // Stage 2: window shift and output register.
  // hist holds the two older columns; the stage-1 registers are the third.
  assign new_col[0] = tap2_data;
  assign new_col[1] = tap1_data;
  assign new_col[2] = pix_p1;

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      win_nxt[win_idx(i, 0)] = hist[i][0];
      win_nxt[win_idx(i, 1)] = hist[i][1];
      win_nxt[win_idx(i, 2)] = new_col[i];
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      for (int i = 0; i < 3; i++) begin
        hist[i][0] <= hist[i][1];
        hist[i][1] <= new_col[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strm.dn_val    <= 1'b0;
      strm.dn_last   <= 1'b0;
      strm.dn_window <= '0;
    end else begin
      strm.dn_val  <= win_p1;
      strm.dn_last <= last_p1;
      if (win_p1) begin
        strm.dn_window <= win_nxt;
      end
    end
  end
endmodule
